serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend, unsigned; sampled on the accepting edge only.
REQ-006 Port: b  input  WIDTH  subtrahend, unsigned; sampled on the accepting edge only.
REQ-007 Port: busy  output  1  high while a subtraction is in progress.
REQ-008 Port: done  output  1  one-cycle pulse marking a valid new result.
REQ-009 Port: diff  output  WIDTH  registered result a - b modulo 2^WIDTH.
REQ-010 Port: borrow  output  1  registered final borrow; 1 exactly when a < b unsigned.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-012 In IDLE with start=1 on a rising edge, the block SHALL:
  - load a and b into internal shift registers;
  - clear the internal borrow flip-flop and the bit counter;
  - enter RUN.
REQ-013 In IDLE with start=0, the state and all outputs except done SHALL hold.
REQ-014 In RUN, each rising edge SHALL process one bit, LSB first:
  - d = a_bit ^ b_bit ^ bq;
  - bq_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bq);
  - this is a full subtractor built from two half subtractors plus an OR gate.
REQ-015 Each RUN edge SHALL shift d into an internal result shift register, shift both operand registers right by one, and increment the counter.
REQ-016 On the RUN edge that processes bit WIDTH-1, the block SHALL:
  - copy the completed result into diff and bq_next into borrow;
  - assert done for exactly the following cycle;
  - return to IDLE.
REQ-017 Latency: start accepted at edge E0 SHALL make busy=1 for exactly WIDTH cycles (after E0 through E0+WIDTH) and done=1 in the cycle after edge E0+WIDTH.
REQ-018 busy and done SHALL never be high in the same cycle.
REQ-019 diff and borrow SHALL hold the previous result throughout RUN and change only on the completing edge.
REQ-020 start asserted while busy=1 SHALL be ignored; it is neither queued nor allowed to alter the operation in progress.
REQ-021 start=1 during the done cycle SHALL be accepted, since the FSM is in IDLE, giving back-to-back operations with no gap cycle.
REQ-022 Changes on a and b after the accepting edge SHALL have no effect on the current result.
REQ-023 Arithmetic wrap-around: diff SHALL equal (a - b + 2^WIDTH) mod 2^WIDTH for all operand pairs.

Reset
REQ-024 rst_n=0 SHALL immediately, independent of clk:
  - force the FSM to IDLE;
  - set busy=0, done=0, diff=0 and borrow=0;
  - clear all shift registers, the counter and the borrow flip-flop.
REQ-025 Reset asserted during RUN SHALL abort the operation with no done pulse, and diff SHALL read 0 afterwards.
REQ-026 After rst_n rises, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-027 WIDTH=8, a=200, b=55, start pulse -> busy high 8 cycles, then done=1 with diff=145 and borrow=0.
REQ-028 WIDTH=8, a=55, b=200 -> diff=111, borrow=1; then a=0, b=1 -> diff=255, borrow=1; then a=0x5A, b=0x5A -> diff=0, borrow=0.
REQ-029 start re-asserted in cycle 3 of RUN with different operands -> ignored; result and done timing match the first operation only.
REQ-030 start held high continuously with a new operand pair each done cycle -> done pulses exactly every WIDTH+1 cycles, each with the correct diff and borrow.
REQ-031 rst_n pulsed low mid-RUN, asynchronous to clk -> busy, done, diff and borrow drop to 0 immediately, no done follows, and the next start completes correctly.
REQ-032 WIDTH=4, exhaustive sweep of all 16x16 operand pairs -> every {borrow, diff} equals the 5-bit value of a - b.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor step per clock, LSB first.
// A result a - b (mod 2^WIDTH) plus final borrow appears WIDTH cycles after start.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_sh_q, res_sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bq_q, bq_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;

  // Full subtractor: two half subtractors chained, borrows ORed.
  logic a_bit, b_bit, hd1, hb1, hb2, d_bit, bq_next;
  logic last_bit;

  always_comb begin
    a_bit    = a_sh_q[0];
    b_bit    = b_sh_q[0];
    hd1      = a_bit ^ b_bit;
    hb1      = ~a_bit & b_bit;
    d_bit    = hd1 ^ bq_q;
    hb2      = ~hd1 & bq_q;
    bq_next  = hb1 | hb2;
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    cnt_d    = cnt_q;
    bq_d     = bq_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          res_sh_d = '0;
          cnt_d    = '0;
          bq_d     = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // Result fills from the MSB end so bit 0 lands in place after WIDTH shifts.
        res_sh_d = {d_bit, res_sh_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        bq_d     = bq_next;
        if (last_bit) begin
          diff_d   = {d_bit, res_sh_q[WIDTH-1:1]};
          borrow_d = bq_next;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      cnt_q    <= '0;
      bq_q     <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      cnt_q    <= cnt_d;
      bq_q     <= bq_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: 8-bit instance for timing/scenarios,
// 4-bit instance for an exhaustive operand sweep.
module tb_serial_subtractor;

  localparam int W  = 8;
  localparam int W4 = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, start4;
  logic [W-1:0]  a, b, diff;
  logic          busy, done, borrow;
  logic [W4-1:0] a4, b4, diff4;
  logic          busy4, done4, borrow4;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] last_diff;
  logic         last_borrow;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  serial_subtractor #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
  );

  always #5 clk = ~clk;

  // Reference: {borrow, diff} from plain unsigned arithmetic.
  function automatic logic [W:0] ref_sub(input int unsigned x, input int unsigned y);
    int unsigned m;
    int unsigned dv;
    m  = 1 << W;
    dv = (x + m - y) % m;
    return {(x < y) ? 1'b1 : 1'b0, dv[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
    a = '0; b = '0; a4 = '0; b4 = '0;
    #3;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%0b done=%0b diff=%0d borrow=%0b exp all 0",
               busy, done, diff, borrow);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%0b done=%0b exp 0 0", busy, done);
    end
    last_diff = '0; last_borrow = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[10];
    logic [W-1:0] tb_[10];
    logic [W:0]   exp;
    ta[0] = 8'd200; tb_[0] = 8'd55;
    ta[1] = 8'd55;  tb_[1] = 8'd200;
    ta[2] = 8'd0;   tb_[2] = 8'd1;
    ta[3] = 8'h5A;  tb_[3] = 8'h5A;
    for (int i = 4; i < 10; i++) begin
      ta[i] = W'($urandom); tb_[i] = W'($urandom);
    end
    for (int i = 0; i < 10; i++) begin
      exp = ref_sub(ta[i], tb_[i]);
      a = ta[i]; b = tb_[i]; start = 1'b1;
      tick();
      start = 1'b0;
      a = W'($urandom); b = W'($urandom);
      for (int k = 0; k < W; k++) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || diff !== last_diff || borrow !== last_borrow) begin
          errors++;
          $display("FAIL run_cycle op=%0d k=%0d got busy=%0b done=%0b diff=%0d borrow=%0b exp 1 0 %0d %0b",
                   i, k, busy, done, diff, borrow, last_diff, last_borrow);
        end
        tick();
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || {borrow, diff} !== exp) begin
        errors++;
        $display("FAIL result op=%0d a=%0d b=%0d got done=%0b busy=%0b diff=%0d borrow=%0b exp diff=%0d borrow=%0b",
                 i, ta[i], tb_[i], done, busy, diff, borrow, exp[W-1:0], exp[W]);
      end
      last_diff = exp[W-1:0]; last_borrow = exp[W];
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || diff !== last_diff) begin
        errors++;
        $display("FAIL done_pulse op=%0d got done=%0b busy=%0b diff=%0d exp 0 0 %0d",
                 i, done, busy, diff, last_diff);
      end
    end
  endtask

  task automatic test_ignore_start();
    a = 8'd200; b = 8'd55; start = 1'b1;
    tick();
    start = 1'b0; a = '0; b = '0;
    tick(); tick();
    start = 1'b1; a = 8'd17; b = 8'd99;
    tick();
    start = 1'b0;
    for (int k = 3; k < W; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL ignore_busy k=%0d got busy=%0b done=%0b exp 1 0", k, busy, done);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || diff !== 8'd145 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result got done=%0b diff=%0d borrow=%0b exp 1 145 0", done, diff, borrow);
    end
    last_diff = 8'd145; last_borrow = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_not_queued got busy=%0b done=%0b exp 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 5;
    logic [W-1:0] pa[N];
    logic [W-1:0] pb[N];
    logic [W:0]   exp;
    int cyc, prev, i;
    for (int j = 0; j < N; j++) begin
      pa[j] = W'($urandom); pb[j] = W'($urandom);
    end
    pa[0] = 8'd3; pb[0] = 8'd250;
    cyc = 0; prev = 0; i = 0;
    a = pa[0]; b = pb[0]; start = 1'b1;
    while (i < N && cyc < N * (W + 1) + 20) begin
      tick();
      cyc++;
      if (busy === 1'b1 && done === 1'b1) begin
        checks++; errors++;
        $display("FAIL b2b_overlap cyc=%0d got busy=1 done=1 exp not both", cyc);
      end
      if (done === 1'b1) begin
        exp = ref_sub(pa[i], pb[i]);
        checks++;
        if ({borrow, diff} !== exp) begin
          errors++;
          $display("FAIL b2b_result op=%0d got diff=%0d borrow=%0b exp diff=%0d borrow=%0b",
                   i, diff, borrow, exp[W-1:0], exp[W]);
        end
        checks++;
        if ((cyc - prev) !== (W + 1)) begin
          errors++;
          $display("FAIL b2b_period op=%0d got %0d cycles exp %0d", i, cyc - prev, W + 1);
        end
        prev = cyc;
        last_diff = exp[W-1:0]; last_borrow = exp[W];
        i++;
        if (i < N) begin
          a = pa[i]; b = pb[i];
        end
      end
    end
    start = 1'b0;
    checks++;
    if (i !== N) begin
      errors++;
      $display("FAIL b2b_timeout got %0d results exp %0d", i, N);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    a = 8'd200; b = 8'd55; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (W) tick();
    checks++;
    if (diff !== 8'd145 || done !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_result got diff=%0d done=%0b exp 145 1", diff, done);
    end
    a = 8'd9; b = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got busy=%0b done=%0b diff=%0d borrow=%0b exp all 0",
               busy, done, diff, borrow);
    end
    tick();
    #2 rst_n = 1'b1;
    last_diff = '0; last_borrow = 1'b0;
    for (int k = 0; k < W + 2; k++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || diff !== '0) begin
        errors++;
        $display("FAIL post_reset_quiet k=%0d got done=%0b busy=%0b diff=%0d exp 0 0 0",
                 k, done, busy, diff);
      end
    end
    a = 8'h10; b = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (W) tick();
    checks++;
    if (done !== 1'b1 || diff !== 8'hF0 || borrow !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_op got done=%0b diff=%0d borrow=%0b exp 1 240 1", done, diff, borrow);
    end
    last_diff = 8'hF0; last_borrow = 1'b1;
    tick();
  endtask

  task automatic test_sweep4();
    int n;
    logic [4:0] e5;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        e5 = 5'(x - y);
        a4 = W4'(x); b4 = W4'(y); start4 = 1'b1;
        tick();
        start4 = 1'b0;
        n = 0;
        while (done4 !== 1'b1 && n < W4 + 4) begin
          tick();
          n++;
        end
        checks++;
        if (done4 !== 1'b1 || n !== W4 || {borrow4, diff4} !== e5) begin
          errors++;
          $display("FAIL sweep4 a=%0d b=%0d got done=%0b lat=%0d val=%0d exp 1 %0d %0d",
                   x, y, done4, n, {borrow4, diff4}, W4, e5);
        end
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
